// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared encodings and default timing for the Tetris button front end
package tetris_pkg;

    // Per-button FSM states. Without TETRIS_AUTOREPEAT_EN, DELAY is reused as
    // the plain "pressed, waiting for release" state and REPEAT is never entered.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_D = 2;
    localparam int BTN_S = 3;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_RATE     = 8_000_000;
    localparam int DEF_CNT_W           = 25;

endpackage

// File: rtl/tetris_debounce.sv
// rtl/tetris_debounce.sv - two-flop synchroniser plus debounce counter for one button
//
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   raw  - asynchronous button input
//   deb  - debounced level; changes only after DEBOUNCE_CYCLES consecutive
//          synchronised cycles that disagree with it
module tetris_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            deb  <= 1'b0;
            cnt  <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= ~deb;
                cnt <= '0;
            end else if (cnt != '1) begin
                // saturate rather than wrap
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tetris_input.sv
// rtl/tetris_input.sv - debounced, edge-detected (optionally auto-repeating) Tetris buttons
//
// Optional feature macro: TETRIS_AUTOREPEAT_EN (auto-repeat on held L/R/D).
//
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   btnL, btnR, btnD, btnS   - raw asynchronous buttons
//   mv_left, mv_right,
//   mv_down, rotate          - registered single-cycle command pulses
//   held[3:0]                - debounced levels {S,D,R,L}
module tetris_input
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnD,
    input  logic       btnS,
    output logic       mv_left,
    output logic       mv_right,
    output logic       mv_down,
    output logic       rotate,
    output logic [3:0] held
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;

    if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
        $error("tetris_input: DEBOUNCE_CYCLES must be at least 2");
    end
    if (CNT_W < $clog2(MAX_CNT + 1)) begin : g_chk_width
        $error("tetris_input: CNT_W too narrow for timing parameters");
    end

    logic [3:0] raw;
    logic [3:0] deb;

    assign raw  = {btnS, btnD, btnR, btnL};
    assign held = deb;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        tetris_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk(clk),
            .rst(rst),
            .raw(raw[g]),
            .deb(deb[g])
        );
    end

    // Both horizontal directions held: neither may move, and both FSMs
    // (including their repeat counters) hold still until one is released.
    logic freeze;
    assign freeze = deb[BTN_L] & deb[BTN_R];

    btn_state_t mv_q [3];
    btn_state_t mv_d [3];
    btn_state_t rot_q;
    btn_state_t rot_d;
    logic [2:0] mv_pulse;
    logic       rot_pulse;

`ifdef TETRIS_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] rcnt_q [3];
    logic [CNT_W-1:0] rcnt_d [3];
`endif

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            mv_d[i]     = mv_q[i];
            mv_pulse[i] = 1'b0;
`ifdef TETRIS_AUTOREPEAT_EN
            rcnt_d[i]   = rcnt_q[i];
`endif
            if (!(freeze && (i == BTN_L || i == BTN_R))) begin
                case (mv_q[i])
                    IDLE: begin
                        if (deb[i]) begin
                            mv_pulse[i] = 1'b1;
                            mv_d[i]     = DELAY;
`ifdef TETRIS_AUTOREPEAT_EN
                            rcnt_d[i]   = '0;
`endif
                        end
                    end
`ifdef TETRIS_AUTOREPEAT_EN
                    DELAY: begin
                        if (!deb[i]) begin
                            mv_d[i] = IDLE;
                        end else if (rcnt_q[i] == DELAY_LAST) begin
                            mv_pulse[i] = 1'b1;
                            rcnt_d[i]   = '0;
                            mv_d[i]     = REPEAT;
                        end else if (rcnt_q[i] != '1) begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!deb[i]) begin
                            mv_d[i] = IDLE;
                        end else if (rcnt_q[i] == RATE_LAST) begin
                            mv_pulse[i] = 1'b1;
                            rcnt_d[i]   = '0;
                        end else if (rcnt_q[i] != '1) begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                    default: mv_d[i] = IDLE;
`else
                    default: begin
                        if (!deb[i]) mv_d[i] = IDLE;
                    end
`endif
                endcase
            end
        end

        // rotate/start is edge-only in every build
        rot_d     = rot_q;
        rot_pulse = 1'b0;
        if (rot_q == IDLE) begin
            if (deb[BTN_S]) begin
                rot_pulse = 1'b1;
                rot_d     = DELAY;
            end
        end else if (!deb[BTN_S]) begin
            rot_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mv_q[i]   <= IDLE;
`ifdef TETRIS_AUTOREPEAT_EN
                rcnt_q[i] <= '0;
`endif
            end
            rot_q    <= IDLE;
            mv_left  <= 1'b0;
            mv_right <= 1'b0;
            mv_down  <= 1'b0;
            rotate   <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                mv_q[i]   <= mv_d[i];
`ifdef TETRIS_AUTOREPEAT_EN
                rcnt_q[i] <= rcnt_d[i];
`endif
            end
            rot_q    <= rot_d;
            mv_left  <= mv_pulse[BTN_L];
            mv_right <= mv_pulse[BTN_R];
            mv_down  <= mv_pulse[BTN_D];
            rotate   <= rot_pulse;
        end
    end

endmodule
